inst_queue: RTL and testbench

Fetch-to-decode instruction queue. Every accepted fetch word is pre-decoded into a branch category and PC offset (B/BL/JIRL/conditional-branch classes) and stored with its PC. Direct jumps, and optionally backward conditional branches, raise a one-cycle fetch redirect. Wrong-path words are squashed until fetch delivers the redirect target. The block sits between the IF stage and the decoder and absorbs back-pressure from decode.

---
 rtl/inst_queue.sv | 155 +++++++++++++++
 tb/tb_inst_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with branch pre-decode and static redirect.
// Define CLAP_CONFIG_STATIC_BTFN_EN to predict backward conditional branches taken.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [1:0]  out_category,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_pc
);

    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  cat;
        logic        taken;
        logic [31:0] pred_pc;
    } entry_t;

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [31:0]        rpc_q, rpc_d;
    logic               rv_q, rv_d;

    logic [1:0]  cat;
    logic [3:0]  op4;
    logic [31:0] offset;
    logic [31:0] target;
    logic        take;
    logic        push;
    logic        pop;
    logic        enq;
    entry_t      new_entry;

    // Pre-decode of the incoming fetch word
    always_comb begin
        op4    = in_inst[29:26];
        cat[1] = (in_inst[31:27] == 5'b01010) || (in_inst[31:26] == 6'b010011);
        cat[0] = (in_inst[31:30] == 2'b01)
              && ((op4 == 4'b0011) || ((op4 >= 4'b0110) && (op4 <= 4'b1011)));
        if (cat == 2'b01) begin
            offset = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};
        end else if (cat == 2'b10) begin
            offset = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
        end else begin
            offset = 32'd4;
        end
        target = in_pc + offset;
`ifdef CLAP_CONFIG_STATIC_BTFN_EN
        take = (cat == 2'b10) || ((cat == 2'b01) && in_inst[25]);
`else
        take = (cat == 2'b10);
`endif
        new_entry.pc      = in_pc;
        new_entry.inst    = in_inst;
        new_entry.cat     = cat;
        new_entry.taken   = take;
        new_entry.pred_pc = take ? target : (in_pc + 32'd4);
    end

    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        rpc_d   = rpc_q;
        rv_d    = 1'b0;
        enq     = 1'b0;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            state_d = S_RUN;
        end else begin
            // In WAIT only the redirect target leaves the wrong path
            enq = push && ((state_q == S_RUN) || (in_pc == rpc_q));
            if (enq) begin
                mem_d[wr_q] = new_entry;
                wr_d        = wr_q + PTR_W'(1);
                state_d     = take ? S_WAIT : S_RUN;
                if (take) begin
                    rpc_d = target;
                    rv_d  = 1'b1;
                end
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            rpc_q   <= '0;
            rv_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            rpc_q   <= rpc_d;
            rv_q    <= rv_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign out_pc         = mem_q[rd_q].pc;
    assign out_inst       = mem_q[rd_q].inst;
    assign out_category   = mem_q[rd_q].cat;
    assign out_pred_taken = mem_q[rd_q].taken;
    assign out_pred_pc    = mem_q[rd_q].pred_pc;

endmodule

// File: tb/tb_inst_queue.sv
// Directed vector bench for inst_queue.
// Expected values follow CLAP_CONFIG_STATIC_BTFN_EN when it is defined.
module tb_inst_queue;

    localparam logic [31:0] NOP = 32'h0340_0000;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  out_category;
    logic        out_pred_taken;
    logic [31:0] out_pred_pc;

    int checks = 0;
    int errors = 0;

    inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_category   (out_category),
        .out_pred_taken (out_pred_taken),
        .out_pred_pc    (out_pred_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  cat;
        logic        taken;
        logic [31:0] pred_pc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [31:0] pc);
        out_ready = 1'b1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_pc"}, out_pc, pc);
        step();
        out_ready = 1'b0;
    endtask

    logic [31:0] q [$];
    int          sent;
    logic        do_push;
    logic        do_pop;

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;

        vecs[0] = '{32'h1c00_0000, 32'h5000_1000, 2'b10, 1'b1, 32'h1c00_0010};
`ifdef CLAP_CONFIG_STATIC_BTFN_EN
        vecs[1] = '{32'h1c00_0100, 32'h5BFF_FC00, 2'b01, 1'b1, 32'h1c00_00FC};
        vecs[6] = '{32'h1c00_0600, 32'h6FFF_F800, 2'b01, 1'b1, 32'h1c00_05F8};
`else
        vecs[1] = '{32'h1c00_0100, 32'h5BFF_FC00, 2'b01, 1'b0, 32'h1c00_0104};
        vecs[6] = '{32'h1c00_0600, 32'h6FFF_F800, 2'b01, 1'b0, 32'h1c00_0604};
`endif
        vecs[2] = '{32'h1c00_0200, 32'h4C00_0020, 2'b11, 1'b0, 32'h1c00_0204};
        vecs[3] = '{32'h1c00_0300, 32'h0280_0000, 2'b00, 1'b0, 32'h1c00_0304};
        vecs[4] = '{32'h1c00_0400, 32'h57FF_FBFF, 2'b10, 1'b1, 32'h1c00_03F8};
        vecs[5] = '{32'h1c00_0500, 32'h5800_0800, 2'b01, 1'b0, 32'h1c00_0504};
        vecs[7] = '{32'hFFFF_FFFC, 32'h5000_1000, 2'b10, 1'b1, 32'h0000_000C};

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_pred_pc", out_pred_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            push(vecs[i].pc, vecs[i].inst);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_inst", i), out_inst, vecs[i].inst);
            chk($sformatf("v%0d_cat", i), 32'(out_category), 32'(vecs[i].cat));
            chk($sformatf("v%0d_taken", i), 32'(out_pred_taken), 32'(vecs[i].taken));
            chk($sformatf("v%0d_pred_pc", i), out_pred_pc, vecs[i].pred_pc);
            chk($sformatf("v%0d_rv", i), 32'(redirect_valid), 32'(vecs[i].taken));
            if (vecs[i].taken) begin
                chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].pred_pc);
            end
            pop_expect($sformatf("v%0d_pop", i), vecs[i].pc);
            chk($sformatf("v%0d_rv_end", i), 32'(redirect_valid), 32'd0);
            chk($sformatf("v%0d_empty", i), 32'(out_valid), 32'd0);
            if (vecs[i].taken) begin
                push(vecs[i].pred_pc, NOP);
                chk($sformatf("v%0d_tgt_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d_tgt_pc", i), out_pc, vecs[i].pred_pc);
                pop_expect($sformatf("v%0d_tgt_pop", i), vecs[i].pred_pc);
            end
        end

        // wrong-path squash
        push(32'h1c00_0000, 32'h5000_1000);
        chk("sq_rv", 32'(redirect_valid), 32'd1);
        chk("sq_rpc", redirect_pc, 32'h1c00_0010);
        push(32'h1c00_0004, NOP);
        chk("sq_rv_once", 32'(redirect_valid), 32'd0);
        push(32'h1c00_0008, NOP);
        push(32'h1c00_0010, NOP);
        push(32'h1c00_0014, NOP);
        chk("sq_rpc_hold", redirect_pc, 32'h1c00_0010);
        pop_expect("sq_pop0", 32'h1c00_0000);
        pop_expect("sq_pop1", 32'h1c00_0010);
        pop_expect("sq_pop2", 32'h1c00_0014);
        chk("sq_empty", 32'(out_valid), 32'd0);

        // redirect target that is itself a taken branch
        push(32'h0000_4000, 32'h5000_1000);
        push(32'h0000_4010, 32'h5000_1000);
        chk("ch_rv", 32'(redirect_valid), 32'd1);
        chk("ch_rpc", redirect_pc, 32'h0000_4020);
        push(32'h0000_4014, NOP);
        push(32'h0000_4020, NOP);
        pop_expect("ch_pop0", 32'h0000_4000);
        pop_expect("ch_pop1", 32'h0000_4010);
        pop_expect("ch_pop2", 32'h0000_4020);
        chk("ch_empty", 32'(out_valid), 32'd0);

        // fill to full, then streaming with wrap-around
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(i * 4), NOP);
            q.push_back(32'h100 + 32'(i * 4));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_pc    = 32'h9999_0000;
        in_inst  = NOP;
        step();
        in_valid = 1'b0;
        chk("full_hold", 32'(in_ready), 32'd0);
        pop_expect("full_pop", q.pop_front());
        chk("full_ready_again", 32'(in_ready), 32'd1);

        sent = 0;
        for (int c = 0; c < 400 && (sent < 20 || q.size() != 0); c++) begin
            in_valid  = (sent < 20);
            in_pc     = 32'h200 + 32'(sent * 4);
            in_inst   = NOP;
            out_ready = 1'($urandom_range(0, 1));
            #0;
            chk("st_in_ready", 32'(in_ready), 32'(q.size() != 8));
            chk("st_out_valid", 32'(out_valid), 32'(q.size() != 0));
            do_push = in_valid && (q.size() != 8);
            do_pop  = out_ready && (q.size() != 0);
            if (do_pop) begin
                chk("st_order", out_pc, q.pop_front());
            end
            if (do_push) begin
                q.push_back(in_pc);
                sent++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("st_sent", 32'(sent), 32'd20);
        chk("st_drained", 32'(out_valid), 32'd0);

        // flush with a taken push in the same cycle
        push(32'h1000, NOP);
        push(32'h1004, NOP);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h1008;
        in_inst  = 32'h5000_1000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_rv", 32'(redirect_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        push(32'h2000, NOP);
        chk("fl_run_valid", 32'(out_valid), 32'd1);
        chk("fl_run_pc", out_pc, 32'h2000);
        pop_expect("fl_pop", 32'h2000);

        // flush while a redirect is pending cancels the squash
        push(32'h3000, 32'h5000_1000);
        chk("fl2_rv", 32'(redirect_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl2_empty", 32'(out_valid), 32'd0);
        chk("fl2_rv_off", 32'(redirect_valid), 32'd0);
        push(32'h3004, NOP);
        chk("fl2_run_valid", 32'(out_valid), 32'd1);
        chk("fl2_run_pc", out_pc, 32'h3004);
        pop_expect("fl2_pop", 32'h3004);

        // asynchronous reset with a redirect pending
        push(32'h5000, 32'h5000_1000);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_rv", 32'(redirect_valid), 32'd0);
        chk("ar_rpc", redirect_pc, 32'd0);
        chk("ar_out_pc", out_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        push(32'h5004, NOP);
        chk("ar_run_pc", out_pc, 32'h5004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
